// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and width helper for the modulo-N digit counter chain
package counter_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Bits needed to hold one digit; a modulus of 2 still needs one bit
    function automatic int digit_w(input int modulus);
        return (modulus <= 2) ? 1 : $clog2(modulus);
    endfunction

endpackage

// File: rtl/mod_counter_chain_if.sv
// rtl/mod_counter_chain_if.sv - control and status bundle of the digit counter chain
interface mod_counter_chain_if
    import counter_pkg::*;
#(
    parameter int MODULUS = 10,
    parameter int DIGITS  = 4
);
    localparam int DIGIT_W = digit_w(MODULUS);

    logic                         i_en;
    logic                         i_dir;
    logic                         i_load;
    logic [DIGITS*DIGIT_W-1:0]    i_load_val;
    logic [DIGITS*DIGIT_W-1:0]    o_count;
    logic [DIGITS-1:0]            o_digit_tc;
    logic                         o_tc;
    logic                         o_at_max;
    logic                         o_at_zero;

    modport master (
        output i_en, i_dir, i_load, i_load_val,
        input  o_count, o_digit_tc, o_tc, o_at_max, o_at_zero
    );

    modport slave (
        input  i_en, i_dir, i_load, i_load_val,
        output o_count, o_digit_tc, o_tc, o_at_max, o_at_zero
    );

endinterface

// File: rtl/mod_counter_digit.sv
// rtl/mod_counter_digit.sv - one modulo-N digit with load clamp and wrap pulse
module mod_counter_digit
    import counter_pkg::*;
#(
    parameter int MODULUS = 10,
    parameter int DIGIT_W = digit_w(MODULUS)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               step,
    input  logic               dir,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    output logic [DIGIT_W-1:0] value,
    output logic               at_max,
    output logic               at_zero,
    output logic               wrap
);

    localparam logic [DIGIT_W-1:0] MAX_V = DIGIT_W'(MODULUS - 1);

    logic [DIGIT_W-1:0] load_clamped;

    // Out-of-range load fields saturate to the top digit value
    always_comb begin
        load_clamped = (load_val > MAX_V) ? MAX_V : load_val;
    end

    // Digit register: reset, then load, then step; wrap pulses only on a wrapping step
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            value <= '0;
            wrap  <= 1'b0;
        end else if (load) begin
            value <= load_clamped;
            wrap  <= 1'b0;
        end else if (step) begin
            if (dir == DIR_UP) begin
                if (at_max) begin
                    value <= '0;
                    wrap  <= 1'b1;
                end else begin
                    value <= value + 1'b1;
                    wrap  <= 1'b0;
                end
            end else begin
                if (at_zero) begin
                    value <= MAX_V;
                    wrap  <= 1'b1;
                end else begin
                    value <= value - 1'b1;
                    wrap  <= 1'b0;
                end
            end
        end else begin
            wrap <= 1'b0;
        end
    end

    assign at_max  = (value == MAX_V);
    assign at_zero = (value == '0);

endmodule

// File: rtl/mod_counter_chain.sv
// rtl/mod_counter_chain.sv - cascadable up/down modulo-N digit counter with load and saturation
module mod_counter_chain
    import counter_pkg::*;
#(
    parameter int MODULUS  = 10,
    parameter int DIGITS   = 4,
    parameter int SATURATE = 0
) (
    input  logic                i_clk,
    input  logic                i_rst,
    mod_counter_chain_if.slave  bus
);

    localparam int DIGIT_W = digit_w(MODULUS);

    logic [DIGITS-1:0]         step_raw;
    logic [DIGITS-1:0]         step;
    logic [DIGITS-1:0]         at_max;
    logic [DIGITS-1:0]         at_zero;
    logic [DIGITS-1:0]         wrap;
    logic [DIGIT_W-1:0]        value [DIGITS];
    logic [DIGITS*DIGIT_W-1:0] count_packed;
    logic                      lower_ok;
    logic                      chain_end;
    logic                      tc_q;

    // Ripple enable: a digit steps only when every lower digit sits at its limit
    always_comb begin
        lower_ok = 1'b1;
        step_raw = '0;
        for (int k = 0; k < DIGITS; k++) begin
            step_raw[k] = bus.i_en & lower_ok;
            lower_ok    = lower_ok & ((bus.i_dir == DIR_UP) ? at_max[k] : at_zero[k]);
        end
        chain_end = bus.i_en & lower_ok;
        step      = ((SATURATE != 0) && chain_end) ? '0 : step_raw;
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        mod_counter_digit #(
            .MODULUS (MODULUS),
            .DIGIT_W (DIGIT_W)
        ) u_digit (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .step     (step[k]),
            .dir      (bus.i_dir),
            .load     (bus.i_load),
            .load_val (bus.i_load_val[k*DIGIT_W +: DIGIT_W]),
            .value    (value[k]),
            .at_max   (at_max[k]),
            .at_zero  (at_zero[k]),
            .wrap     (wrap[k])
        );
    end

    // Pack the digit registers into the output word, digit 0 in the low bits
    always_comb begin
        count_packed = '0;
        for (int k = 0; k < DIGITS; k++) begin
            count_packed[k*DIGIT_W +: DIGIT_W] = value[k];
        end
    end

    // Chain terminal-count pulse; also fires on a suppressed step when saturating
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tc_q <= 1'b0;
        end else if (bus.i_load) begin
            tc_q <= 1'b0;
        end else begin
            tc_q <= chain_end;
        end
    end

    assign bus.o_count    = count_packed;
    assign bus.o_digit_tc = wrap;
    assign bus.o_tc       = tc_q;
    assign bus.o_at_max   = &at_max;
    assign bus.o_at_zero  = &at_zero;

endmodule

// File: tb/tb_mod_counter_chain.sv
// tb/tb_mod_counter_chain.sv - scoreboard bench for four counter chain configurations
module tb_mod_counter_chain;

    typedef struct {
        logic [15:0] cnt;
        logic [3:0]  dtc;
        logic        tc;
        logic        amax;
        logic        azero;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        dir;
    logic        load;
    logic [15:0] lv;

    int n_tests = 0;
    int n_fail  = 0;

    // DUT configurations: modulus, digit count, saturate
    int pm [4] = '{10, 10, 10, 16};
    int pd [4] = '{2, 2, 4, 3};
    int ps [4] = '{0, 1, 0, 1};

    int   md [4][4];
    exp_t sb [4][$];

    logic [15:0] o_cnt   [4];
    logic [3:0]  o_dtc   [4];
    logic        o_tc    [4];
    logic        o_amax  [4];
    logic        o_azero [4];

    always #5 clk = ~clk;

    mod_counter_chain_if #(.MODULUS(10), .DIGITS(2)) if_a ();
    mod_counter_chain_if #(.MODULUS(10), .DIGITS(2)) if_b ();
    mod_counter_chain_if #(.MODULUS(10), .DIGITS(4)) if_c ();
    mod_counter_chain_if #(.MODULUS(16), .DIGITS(3)) if_d ();

    mod_counter_chain #(.MODULUS(10), .DIGITS(2), .SATURATE(0)) dut_a (.i_clk(clk), .i_rst(rst), .bus(if_a));
    mod_counter_chain #(.MODULUS(10), .DIGITS(2), .SATURATE(1)) dut_b (.i_clk(clk), .i_rst(rst), .bus(if_b));
    mod_counter_chain #(.MODULUS(10), .DIGITS(4), .SATURATE(0)) dut_c (.i_clk(clk), .i_rst(rst), .bus(if_c));
    mod_counter_chain #(.MODULUS(16), .DIGITS(3), .SATURATE(1)) dut_d (.i_clk(clk), .i_rst(rst), .bus(if_d));

    assign if_a.i_en = en;  assign if_a.i_dir = dir;  assign if_a.i_load = load;  assign if_a.i_load_val = lv[7:0];
    assign if_b.i_en = en;  assign if_b.i_dir = dir;  assign if_b.i_load = load;  assign if_b.i_load_val = lv[7:0];
    assign if_c.i_en = en;  assign if_c.i_dir = dir;  assign if_c.i_load = load;  assign if_c.i_load_val = lv;
    assign if_d.i_en = en;  assign if_d.i_dir = dir;  assign if_d.i_load = load;  assign if_d.i_load_val = lv[11:0];

    assign o_cnt[0] = 16'(if_a.o_count);  assign o_dtc[0] = 4'(if_a.o_digit_tc);
    assign o_cnt[1] = 16'(if_b.o_count);  assign o_dtc[1] = 4'(if_b.o_digit_tc);
    assign o_cnt[2] = if_c.o_count;       assign o_dtc[2] = if_c.o_digit_tc;
    assign o_cnt[3] = 16'(if_d.o_count);  assign o_dtc[3] = 4'(if_d.o_digit_tc);
    assign o_tc[0] = if_a.o_tc;  assign o_amax[0] = if_a.o_at_max;  assign o_azero[0] = if_a.o_at_zero;
    assign o_tc[1] = if_b.o_tc;  assign o_amax[1] = if_b.o_at_max;  assign o_azero[1] = if_b.o_at_zero;
    assign o_tc[2] = if_c.o_tc;  assign o_amax[2] = if_c.o_at_max;  assign o_azero[2] = if_c.o_at_zero;
    assign o_tc[3] = if_d.o_tc;  assign o_amax[3] = if_d.o_at_max;  assign o_azero[3] = if_d.o_at_zero;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Digit-level reference: find the lowest digit not at its limit, wrap everything below it
    task automatic model(input int i, input logic r, input logic l, input logic [15:0] v,
                         input logic e, input logic d);
        exp_t x;
        int   m;
        int   fld;
        bit   all_end;
        bit   done;
        m        = pm[i];
        x.dtc    = '0;
        x.tc     = 1'b0;
        if (r) begin
            for (int k = 0; k < 4; k++) md[i][k] = 0;
        end else if (l) begin
            for (int k = 0; k < pd[i]; k++) begin
                fld = int'(v[k*4 +: 4]);
                md[i][k] = (fld >= m) ? m - 1 : fld;
            end
        end else if (e) begin
            all_end = 1'b1;
            for (int k = 0; k < pd[i]; k++)
                if (md[i][k] != (d ? 0 : m - 1)) all_end = 1'b0;
            if (all_end) begin
                x.tc = 1'b1;
                if (ps[i] == 0) begin
                    for (int k = 0; k < pd[i]; k++) begin
                        md[i][k] = d ? m - 1 : 0;
                        x.dtc[k] = 1'b1;
                    end
                end
            end else begin
                done = 1'b0;
                for (int k = 0; k < pd[i]; k++) begin
                    if (!done) begin
                        if (md[i][k] == (d ? 0 : m - 1)) begin
                            md[i][k] = d ? m - 1 : 0;
                            x.dtc[k] = 1'b1;
                        end else begin
                            md[i][k] = d ? md[i][k] - 1 : md[i][k] + 1;
                            done = 1'b1;
                        end
                    end
                end
            end
        end
        x.cnt   = '0;
        x.amax  = 1'b1;
        x.azero = 1'b1;
        for (int k = 0; k < pd[i]; k++) begin
            x.cnt = x.cnt | (16'(md[i][k]) << (4 * k));
            if (md[i][k] != m - 1) x.amax = 1'b0;
            if (md[i][k] != 0)     x.azero = 1'b0;
        end
        sb[i].push_back(x);
    endtask

    task automatic cyc(input logic r, input logic l, input logic [15:0] v, input logic e, input logic d);
        exp_t x;
        rst = r; load = l; lv = v; en = e; dir = d;
        for (int i = 0; i < 4; i++) model(i, r, l, v, e, d);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (sb[i].size() == 0) begin
                check($sformatf("d%0d scoreboard empty", i), 32'd0, 32'd1);
            end else begin
                x = sb[i].pop_front();
                check($sformatf("d%0d count", i),    32'(o_cnt[i]),   32'(x.cnt));
                check($sformatf("d%0d digit_tc", i), 32'(o_dtc[i]),   32'(x.dtc));
                check($sformatf("d%0d tc", i),       32'(o_tc[i]),    32'(x.tc));
                check($sformatf("d%0d at_max", i),   32'(o_amax[i]),  32'(x.amax));
                check($sformatf("d%0d at_zero", i),  32'(o_azero[i]), 32'(x.azero));
            end
        end
    endtask

    int a_dtc0;
    int a_tcs;

    initial begin
        rst = 1'b1; load = 1'b0; lv = '0; en = 1'b0; dir = 1'b0;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) md[i][k] = 0;

        // Reset state
        cyc(1, 0, 16'h0000, 0, 0);
        check("reset count",   32'(o_cnt[0]),   32'h0);
        check("reset at_zero", 32'(o_azero[0]), 32'h1);
        check("reset at_max",  32'(o_amax[0]),  32'h0);

        // Twelve up steps
        a_dtc0 = 0;
        a_tcs  = 0;
        repeat (12) begin
            cyc(0, 0, 16'h0000, 1, 0);
            a_dtc0 += int'(o_dtc[0][0]);
            a_tcs  += int'(o_tc[0]);
        end
        check("t1 count",      32'(o_cnt[0]), 32'h12);
        check("t1 dtc0 pulses", 32'(a_dtc0),  32'd1);
        check("t1 tc pulses",   32'(a_tcs),   32'd0);

        // Overflow wrap versus saturate at all-max
        cyc(0, 1, 16'h0099, 0, 0);
        cyc(0, 0, 16'h0000, 1, 0);
        check("t2 wrap count", 32'(o_cnt[0]), 32'h00);
        check("t2 wrap tc",    32'(o_tc[0]),  32'h1);
        check("t2 wrap dtc",   32'(o_dtc[0]), 32'h3);
        check("t2 sat count",  32'(o_cnt[1]), 32'h99);
        check("t2 sat tc",     32'(o_tc[1]),  32'h1);
        cyc(0, 0, 16'h0000, 0, 0);
        check("t2 tc cleared", 32'(o_tc[0]),  32'h0);

        // Saturating down steps at all-zero
        cyc(0, 1, 16'h0000, 0, 0);
        repeat (3) begin
            cyc(0, 0, 16'h0000, 1, 1);
            check("t3 sat count", 32'(o_cnt[1]), 32'h00);
            check("t3 sat tc",    32'(o_tc[1]),  32'h1);
            check("t3 sat dtc",   32'(o_dtc[1]), 32'h0);
        end

        // Borrow and load clamp
        cyc(0, 1, 16'h0020, 0, 0);
        cyc(0, 0, 16'h0000, 1, 1);
        check("t4 borrow count", 32'(o_cnt[0]), 32'h19);
        check("t4 borrow dtc",   32'(o_dtc[0]), 32'h1);
        cyc(0, 1, 16'h00FA, 0, 0);
        check("t4 clamp count",  32'(o_cnt[0]), 32'h99);

        // Priority: reset over load over step
        cyc(0, 1, 16'h0055, 0, 0);
        cyc(1, 1, 16'h0033, 1, 0);
        check("t5 rst count", 32'(o_cnt[0]), 32'h00);
        check("t5 rst dtc",   32'(o_dtc[0]), 32'h0);
        check("t5 rst tc",    32'(o_tc[0]),  32'h0);
        cyc(0, 1, 16'h0042, 1, 0);
        check("t5 load wins", 32'(o_cnt[0]), 32'h42);

        // Randomised traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(0, 63) == 0),
                ($urandom_range(0, 7) == 0),
                16'($urandom),
                ($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
